// File: rtl/spi_rdid_responder.sv
// spi_rdid_responder: SPI flash-side responder for the RDID (JEDEC ID) command.
// Oversamples SPICLK / chip_select / SPIMOSI on CCLK, decodes the first byte
// of each transaction and, on RDID_CMD, streams {MAN_ID, MEM_TYPE, MEM_CAP}
// MSB first (SPI mode 0), repeating for as long as the master keeps clocking.
// Optional build macro: MISO_HIGHZ_EN -- when defined, SPIMISO floats (1'bz)
// whenever the responder is deselected/idle so MISO can be shared.
module spi_rdid_responder #(
  parameter logic [7:0] MAN_ID      = 8'h20,
  parameter logic [7:0] MEM_TYPE    = 8'h20,
  parameter logic [7:0] MEM_CAP     = 8'h15,
  parameter logic [7:0] RDID_CMD    = 8'h9F,
  parameter int         SYNC_STAGES = 2,
  parameter int         COUNT_W     = 8
) (
  input  logic               CCLK,
  input  logic               reset,
  input  logic               SPICLK,
  input  logic               chip_select,
  input  logic               SPIMOSI,
  output logic               SPIMISO,
  output logic               busy,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte,
  output logic               rdid_done,
  output logic [COUNT_W-1:0] rdid_count
);

  localparam logic [23:0] ID_WORD = {MAN_ID, MEM_TYPE, MEM_CAP};

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

  state_t state_reg, state_next;

  // Synchronizer chains; valid_sr tracks when each stage holds a real pin sample
  logic [SYNC_STAGES-1:0] sclk_sr_reg, sclk_sr_next;
  logic [SYNC_STAGES-1:0] cs_sr_reg, cs_sr_next;
  logic [SYNC_STAGES-1:0] mosi_sr_reg, mosi_sr_next;
  logic [SYNC_STAGES-1:0] valid_sr_reg, valid_sr_next;

  logic sclk_sync, cs_sync, mosi_sync, sync_ok;
  logic sclk_prev_reg;
  logic sclk_rise, sclk_fall;
  logic armed_reg;

  logic [6:0]         shift_reg;
  logic [7:0]         cmd_capture;
  logic [4:0]         bit_cnt_reg;
  logic               miso_reg;
  logic               busy_reg;
  logic               cmd_valid_reg;
  logic [7:0]         cmd_byte_reg;
  logic               rdid_done_reg;
  logic [COUNT_W-1:0] rdid_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sclk_sr_next[gi]  = SPICLK;
        assign cs_sr_next[gi]    = chip_select;
        assign mosi_sr_next[gi]  = SPIMOSI;
        assign valid_sr_next[gi] = 1'b1;
      end else begin : g_rest
        assign sclk_sr_next[gi]  = sclk_sr_reg[gi-1];
        assign cs_sr_next[gi]    = cs_sr_reg[gi-1];
        assign mosi_sr_next[gi]  = mosi_sr_reg[gi-1];
        assign valid_sr_next[gi] = valid_sr_reg[gi-1];
      end
    end
  endgenerate

  assign sclk_sync   = sclk_sr_reg[SYNC_STAGES-1];
  assign cs_sync     = cs_sr_reg[SYNC_STAGES-1];
  assign mosi_sync   = mosi_sr_reg[SYNC_STAGES-1];
  assign sync_ok     = valid_sr_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_sync & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_sync & sclk_prev_reg;
  assign cmd_capture = {shift_reg, mosi_sync};

  // Synchronizer shift, SPICLK edge history and the select arming flag.
  // armed_reg only sets once a genuine (post-reset) high select is seen, so a
  // reset in the middle of a transaction ignores the rest of that transaction.
  always_ff @(posedge CCLK) begin
    if (reset) begin
      sclk_sr_reg   <= '0;
      cs_sr_reg     <= '1;
      mosi_sr_reg   <= '0;
      valid_sr_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_sr_reg   <= sclk_sr_next;
      cs_sr_reg     <= cs_sr_next;
      mosi_sr_reg   <= mosi_sr_next;
      valid_sr_reg  <= valid_sr_next;
      sclk_prev_reg <= sclk_sync;
      armed_reg     <= armed_reg | (sync_ok & cs_sync);
    end
  end

  // FSM state register
  always_ff @(posedge CCLK) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: deselect always wins over a coincident SPICLK edge
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !cs_sync) begin
          state_next = CMD;
        end
      end
      CMD: begin
        if (cs_sync) begin
          state_next = IDLE;
        end else if (sclk_rise && bit_cnt_reg == 5'd7) begin
          state_next = (cmd_capture == RDID_CMD) ? RESP : IGNORE;
        end
      end
      RESP, IGNORE: begin
        if (cs_sync) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command shift-in, ID shift-out, pulses and transaction counter
  always_ff @(posedge CCLK) begin
    if (reset) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      miso_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      cmd_byte_reg   <= 8'h00;
      rdid_done_reg  <= 1'b0;
      rdid_count_reg <= '0;
    end else begin
      cmd_valid_reg <= 1'b0;
      rdid_done_reg <= 1'b0;
      busy_reg      <= ~cs_sync;
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= '0;
          miso_reg    <= 1'b0;
        end
        CMD: begin
          if (cs_sync) begin
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
          end else if (sclk_rise) begin
            shift_reg <= cmd_capture[6:0];
            if (bit_cnt_reg == 5'd7) begin
              cmd_byte_reg  <= cmd_capture;
              cmd_valid_reg <= 1'b1;
              bit_cnt_reg   <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        RESP: begin
          if (cs_sync) begin
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
          end else if (sclk_fall) begin
            miso_reg <= ID_WORD[5'd23 - bit_cnt_reg];
          end else if (sclk_rise) begin
            if (bit_cnt_reg == 5'd23) begin
              bit_cnt_reg   <= '0;
              rdid_done_reg <= 1'b1;
              if (rdid_count_reg != {COUNT_W{1'b1}}) begin
                rdid_count_reg <= rdid_count_reg + 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        IGNORE: begin
          miso_reg <= 1'b0;
          if (cs_sync) begin
            bit_cnt_reg <= '0;
          end
        end
        default: begin
          bit_cnt_reg <= '0;
          miso_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Output decode; MISO optionally floats while idle/deselected
  always_comb begin
`ifdef MISO_HIGHZ_EN
    SPIMISO = (state_reg == IDLE) ? 1'bz : miso_reg;
`else
    SPIMISO = miso_reg;
`endif
    busy       = busy_reg;
    cmd_valid  = cmd_valid_reg;
    cmd_byte   = cmd_byte_reg;
    rdid_done  = rdid_done_reg;
    rdid_count = rdid_count_reg;
  end

endmodule

// File: doc/spi_rdid_responder.md
Name: spi_rdid_responder

Overview:
Synthesizable SPI flash-side responder: the slave end of the RDID exchange. Runs on the system clock and oversamples SPICLK, chip_select and SPIMOSI from an external SPI master. Decodes the first byte of each transaction; on RDID (0x9F) it shifts out a 3-byte JEDEC ID MSB first, SPI mode 0. Serves as an on-board flash emulator and as a synthesizable stand-in for the flash model when exercising the RDID master.

Parameters:
MAN_ID, 8'h20, manufacturer ID byte, sent first
MEM_TYPE, 8'h20, memory type byte, sent second
MEM_CAP, 8'h15, memory capacity byte, sent third
RDID_CMD, 8'h9F, opcode that triggers the ID response
SYNC_STAGES, 2, flip-flop synchronizer depth on SPICLK/chip_select/SPIMOSI (minimum 2)
COUNT_W, 8, width of the saturating RDID transaction counter

Ports:
CCLK  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
SPICLK  input  1  SPI clock from master, idles low
chip_select  input  1  SPI select, active low
SPIMOSI  input  1  master-out data, sampled on SPICLK rising edge
SPIMISO  output  1  slave-out data, changes after SPICLK falling edge
busy  output  1  high while chip_select (synchronized) is low
cmd_valid  output  1  one-CCLK pulse when 8th command bit captured
cmd_byte  output  8  last captured command byte, held until next capture
rdid_done  output  1  one-CCLK pulse when 24th ID bit has been sampled by master
rdid_count  output  COUNT_W  number of completed RDID transactions, saturating

Behaviour:
- Reset (sync, active high): state IDLE, SPIMISO=0, busy=0, cmd_valid=0, cmd_byte=8'h00, rdid_done=0, rdid_count=0, bit counter=0, synchronizers cleared to SPICLK=0, chip_select=1, SPIMOSI=0.
- Inputs pass through SYNC_STAGES flops; rise/fall of SPICLK detected by comparing last two synchronized samples. Detected edge lags the pin edge by SYNC_STAGES+1 CCLK cycles.
- Timing requirement: each SPICLK high and low phase at least 4 CCLK cycles; chip_select setup/hold to SPICLK at least 4 CCLK cycles.
- States: IDLE, CMD, RESP, IGNORE.
- IDLE: SPIMISO=0; synchronized chip_select falling -> CMD, bit counter=0.
- CMD: on each SPICLK rise, shift SPIMOSI into shift register MSB first, counter++. On the 8th rise: cmd_byte<=captured byte, cmd_valid pulses the same cycle. If byte==RDID_CMD -> RESP, load 24-bit ID {MAN_ID,MEM_TYPE,MEM_CAP}, counter=0. Otherwise -> IGNORE.
- RESP: on each SPICLK fall, SPIMISO<=ID[23-counter]. The first fall after the 8th command rise presents ID bit 23. On each SPICLK rise, counter++. On the 24th rise, rdid_done pulses, rdid_count increments (holds at all-ones), and the ID pointer wraps to bit 23. Further clocks repeat the 24-bit ID continuously.
- IGNORE: SPIMISO=0, no shifting, until deselect.
- Synchronized chip_select rising in any state -> IDLE next cycle. Counter cleared, SPIMISO=0. A partial RDID (<24 bits) gives no rdid_done and no count.
- busy = synchronized chip_select inverted, registered.
- SPICLK edges while deselected are ignored. chip_select falling and SPICLK edge in the same cycle: the select transition is handled first, and the edge is ignored.
- reset asserted mid-transaction: immediate IDLE. The remainder of that transaction is ignored until chip_select goes high then low again.

Optional Feature:
MISO_HIGHZ_EN: when defined, SPIMISO is driven 1'bz whenever synchronized chip_select is high (IDLE state or reset), allowing a shared MISO line. When undefined, SPIMISO drives 0 in those conditions. Behaviour while selected is identical either way.

Test Plan:
- Reset then idle bus with chip_select=1 -> SPIMISO=0 (z with MISO_HIGHZ_EN), busy=0, rdid_count=0, cmd_byte=8'h00.
- Master sends 8'h9F then 24 clocks, SPICLK period 40 CCLK -> master captures 8'h20, 8'h20, 8'h15; cmd_valid pulses once with cmd_byte=8'h9F; rdid_done pulses once; rdid_count=1.
- Two back-to-back RDID transactions -> identical bytes both times, rdid_count=2. Custom parameters MAN_ID=8'hC2, MEM_CAP=8'h17 -> master reads C2,20,17.
- Send 8'h05 then 24 clocks -> cmd_byte=8'h05, SPIMISO stays 0, no rdid_done, rdid_count unchanged.
- RDID with chip_select raised after 12 response bits -> busy falls, state IDLE, no rdid_done, count unchanged. A following full RDID returns 20,20,15.
- RDID continued for 48 response clocks -> ID sequence 20,20,15,20,20,15; rdid_done pulses twice; rdid_count +2. With COUNT_W=2 after 5 transactions -> rdid_count=3.
